// File: rtl/segre_mm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// segre_mm_arbiter_pkg
// Shared types and sizes for the main-memory port sequencer.
//   ADDR_SIZE        : main memory address width
//   DCACHE_LANE_SIZE : cache line width, identical for the $I and $D caches
//   LANE_W           : line width carried over the memory port
//   mm_arb_state_e   : sequencer state (IDLE, WR_WAIT, RD_WAIT)
//   mm_owner_e       : which requester currently owns the memory port
// -----------------------------------------------------------------------------
package segre_mm_arbiter_pkg;

  localparam int ADDR_SIZE        = 32;
  localparam int DCACHE_LANE_SIZE = 128;
  localparam int LANE_W           = DCACHE_LANE_SIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WR_WAIT = 2'b01,
    RD_WAIT = 2'b10
  } mm_arb_state_e;

  typedef enum logic [1:0] {
    MM_NONE  = 2'b00,
    MM_IC    = 2'b01,
    MM_DC_RD = 2'b10,
    MM_DC_WB = 2'b11
  } mm_owner_e;

endpackage

// File: rtl/segre_mm_arbiter_if.sv
// -----------------------------------------------------------------------------
// segre_mm_arbiter_if
// Bundles the cache-side request/response signals and the main-memory pins
// handled by segre_mm_arbiter. Signal suffixes are from the arbiter's view.
//   $I fill     : ic_req_i, ic_addr_i -> ic_rdy_o, ic_data_o
//   $D fill     : dc_rd_req_i, dc_rd_addr_i -> dc_rd_rdy_o, dc_data_o
//   $D wb       : dc_wb_req_i, dc_wb_addr_i, dc_wb_data_i -> dc_wb_done_o
//   memory pins : mm_rd_o, mm_wr_o, mm_addr_o, mm_wr_addr_o, mm_wr_data_o,
//                 mm_data_rdy_i, mm_rd_data_i
// Modports:
//   master : the arbiter itself
//   slave  : the surrounding caches and memory (or a testbench)
// -----------------------------------------------------------------------------
interface segre_mm_arbiter_if;
  import segre_mm_arbiter_pkg::*;

  // $I fill channel
  logic                 ic_req_i;
  logic [ADDR_SIZE-1:0] ic_addr_i;
  logic                 ic_rdy_o;
  logic [LANE_W-1:0]    ic_data_o;

  // $D fill channel
  logic                 dc_rd_req_i;
  logic [ADDR_SIZE-1:0] dc_rd_addr_i;
  logic                 dc_rd_rdy_o;
  logic [LANE_W-1:0]    dc_data_o;

  // $D writeback channel
  logic                 dc_wb_req_i;
  logic [ADDR_SIZE-1:0] dc_wb_addr_i;
  logic [LANE_W-1:0]    dc_wb_data_i;
  logic                 dc_wb_done_o;

  // Main memory pins
  logic                 mm_rd_o;
  logic                 mm_wr_o;
  logic [ADDR_SIZE-1:0] mm_addr_o;
  logic [ADDR_SIZE-1:0] mm_wr_addr_o;
  logic [LANE_W-1:0]    mm_wr_data_o;
  logic                 mm_data_rdy_i;
  logic [LANE_W-1:0]    mm_rd_data_i;

  modport master (
    input  ic_req_i, ic_addr_i,
    output ic_rdy_o, ic_data_o,
    input  dc_rd_req_i, dc_rd_addr_i,
    output dc_rd_rdy_o, dc_data_o,
    input  dc_wb_req_i, dc_wb_addr_i, dc_wb_data_i,
    output dc_wb_done_o,
    output mm_rd_o, mm_wr_o, mm_addr_o, mm_wr_addr_o, mm_wr_data_o,
    input  mm_data_rdy_i, mm_rd_data_i
  );

  modport slave (
    output ic_req_i, ic_addr_i,
    input  ic_rdy_o, ic_data_o,
    output dc_rd_req_i, dc_rd_addr_i,
    input  dc_rd_rdy_o, dc_data_o,
    output dc_wb_req_i, dc_wb_addr_i, dc_wb_data_i,
    input  dc_wb_done_o,
    input  mm_rd_o, mm_wr_o, mm_addr_o, mm_wr_addr_o, mm_wr_data_o,
    output mm_data_rdy_i, mm_rd_data_i
  );

endinterface

// File: rtl/segre_mm_arbiter.sv
// -----------------------------------------------------------------------------
// segre_mm_arbiter
// Serialises $I line fills, $D line fills and $D dirty-line writebacks onto the
// core's single main-memory port, one transaction at a time. Writebacks win
// over fills so a victim always reaches memory before its set is refilled; the
// two fill sources share the rest round-robin.
// Ports:
//   clk_i   : core clock, all state on the rising edge
//   rsn_i   : asynchronous active-low reset, aborts any transaction silently
//   bus     : cache request/response channels and memory pins (master view)
//   busy_o  : a memory transaction is outstanding
//   owner_o : requester owning the memory port (mm_owner_e encoding)
// Every output comes straight from a flop, so nothing passes combinationally
// from an input to an output.
// -----------------------------------------------------------------------------
module segre_mm_arbiter
  import segre_mm_arbiter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rsn_i,
  segre_mm_arbiter_if.master  bus,
  output logic                busy_o,
  output logic [1:0]          owner_o
);

  mm_arb_state_e        state_q, state_d;
  mm_owner_e            owner_q, owner_d;
  mm_owner_e            rr_last_q, rr_last_d;

  logic                 mm_rd_q, mm_rd_d;
  logic                 mm_wr_q, mm_wr_d;
  logic [ADDR_SIZE-1:0] mm_addr_q, mm_addr_d;
  logic [ADDR_SIZE-1:0] mm_wr_addr_q, mm_wr_addr_d;
  logic [LANE_W-1:0]    mm_wr_data_q, mm_wr_data_d;

  logic                 ic_rdy_q, ic_rdy_d;
  logic                 dc_rd_rdy_q, dc_rd_rdy_d;
  logic                 dc_wb_done_q, dc_wb_done_d;
  logic [LANE_W-1:0]    ic_data_q, ic_data_d;
  logic [LANE_W-1:0]    dc_data_q, dc_data_d;
  logic                 busy_q, busy_d;

  logic                 ic_elig;
  logic                 dc_rd_elig;
  logic                 dc_wb_elig;
  mm_owner_e            fill_pick;

  // Chooses between the two fill sources. When both want the port, the one
  // that was not granted most recently wins.
  function automatic mm_owner_e pick_fill(input logic      ic_ok,
                                          input logic      dc_ok,
                                          input mm_owner_e last);
    mm_owner_e pick;
    pick = MM_NONE;
    if (ic_ok && dc_ok) begin
      pick = (last == MM_IC) ? MM_DC_RD : MM_IC;
    end else if (ic_ok) begin
      pick = MM_IC;
    end else if (dc_ok) begin
      pick = MM_DC_RD;
    end
    return pick;
  endfunction

  // A requester sees its response pulse one cycle before it can drop its
  // level request, so that request is masked while its own pulse is high.
  always_comb begin
    ic_elig    = bus.ic_req_i    && !ic_rdy_q;
    dc_rd_elig = bus.dc_rd_req_i && !dc_rd_rdy_q;
    dc_wb_elig = bus.dc_wb_req_i && !dc_wb_done_q;
    fill_pick  = pick_fill(ic_elig, dc_rd_elig, rr_last_q);
  end

  // Next-state and next-output logic. Requests are only looked at in IDLE;
  // memory completions are only honoured while a transaction is open.
  // Memory request levels and busy are derived from the next state so they
  // rise the cycle after the grant and fall together with the response pulse.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    mm_addr_d    = mm_addr_q;
    mm_wr_addr_d = mm_wr_addr_q;
    mm_wr_data_d = mm_wr_data_q;
    ic_data_d    = ic_data_q;
    dc_data_d    = dc_data_q;
    ic_rdy_d     = 1'b0;
    dc_rd_rdy_d  = 1'b0;
    dc_wb_done_d = 1'b0;
    mm_rd_d      = 1'b0;
    mm_wr_d      = 1'b0;
    busy_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dc_wb_elig) begin
          state_d      = WR_WAIT;
          owner_d      = MM_DC_WB;
          mm_wr_addr_d = bus.dc_wb_addr_i;
          mm_wr_data_d = bus.dc_wb_data_i;
        end else if (fill_pick != MM_NONE) begin
          state_d   = RD_WAIT;
          owner_d   = fill_pick;
          rr_last_d = fill_pick;
          mm_addr_d = (fill_pick == MM_IC) ? bus.ic_addr_i : bus.dc_rd_addr_i;
        end
      end

      WR_WAIT: begin
        if (bus.mm_data_rdy_i) begin
          state_d      = IDLE;
          owner_d      = MM_NONE;
          dc_wb_done_d = 1'b1;
        end
      end

      RD_WAIT: begin
        if (bus.mm_data_rdy_i) begin
          state_d = IDLE;
          owner_d = MM_NONE;
          if (owner_q == MM_IC) begin
            ic_data_d = bus.mm_rd_data_i;
            ic_rdy_d  = 1'b1;
          end else begin
            dc_data_d   = bus.mm_rd_data_i;
            dc_rd_rdy_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = MM_NONE;
      end
    endcase

    mm_rd_d = (state_d == RD_WAIT);
    mm_wr_d = (state_d == WR_WAIT);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers. Reset clears everything, including the
  // returned data lines and the latched addresses, and leaves the round-robin
  // pointer saying $I was served last.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q      <= IDLE;
      owner_q      <= MM_NONE;
      rr_last_q    <= MM_IC;
      mm_rd_q      <= 1'b0;
      mm_wr_q      <= 1'b0;
      mm_addr_q    <= '0;
      mm_wr_addr_q <= '0;
      mm_wr_data_q <= '0;
      ic_rdy_q     <= 1'b0;
      dc_rd_rdy_q  <= 1'b0;
      dc_wb_done_q <= 1'b0;
      ic_data_q    <= '0;
      dc_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      mm_rd_q      <= mm_rd_d;
      mm_wr_q      <= mm_wr_d;
      mm_addr_q    <= mm_addr_d;
      mm_wr_addr_q <= mm_wr_addr_d;
      mm_wr_data_q <= mm_wr_data_d;
      ic_rdy_q     <= ic_rdy_d;
      dc_rd_rdy_q  <= dc_rd_rdy_d;
      dc_wb_done_q <= dc_wb_done_d;
      ic_data_q    <= ic_data_d;
      dc_data_q    <= dc_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mm_rd_o      = mm_rd_q;
  assign bus.mm_wr_o      = mm_wr_q;
  assign bus.mm_addr_o    = mm_addr_q;
  assign bus.mm_wr_addr_o = mm_wr_addr_q;
  assign bus.mm_wr_data_o = mm_wr_data_q;
  assign bus.ic_rdy_o     = ic_rdy_q;
  assign bus.ic_data_o    = ic_data_q;
  assign bus.dc_rd_rdy_o  = dc_rd_rdy_q;
  assign bus.dc_data_o    = dc_data_q;
  assign bus.dc_wb_done_o = dc_wb_done_q;
  assign busy_o           = busy_q;
  assign owner_o          = owner_q;

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_segre_mm_arbiter
// Directed bench for segre_mm_arbiter with a fixed-latency memory model.
// -----------------------------------------------------------------------------
module tb_segre_mm_arbiter;
  import segre_mm_arbiter_pkg::*;

  localparam int LAT = 4;

  logic       clk_i = 1'b0;
  logic       rsn_i = 1'b0;
  logic       busy_o;
  logic [1:0] owner_o;

  int checks = 0;
  int errors = 0;

  segre_mm_arbiter_if bus ();

  segre_mm_arbiter dut (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .bus     (bus.master),
    .busy_o  (busy_o),
    .owner_o (owner_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory line contents as a function of the address
  function automatic logic [127:0] line_for(input logic [31:0] a);
    return {a ^ 32'h1111_1111, a ^ 32'h2222_2222, a ^ 32'h3333_3333, a ^ 32'h4444_4444};
  endfunction

  // Memory model: completes a request in its (LAT+1)-th cycle of being high
  int           mem_cnt = 0;
  logic         mem_rdy = 1'b0;
  logic [127:0] mem_rd_data = '0;
  logic [31:0]  mem_wa = '0;
  logic [127:0] mem_wd = '0;
  logic         spur_rdy = 1'b0;
  logic         both_seen = 1'b0;

  always @(negedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      mem_cnt <= 0;
      mem_rdy <= 1'b0;
    end else if (bus.mm_rd_o || bus.mm_wr_o) begin
      mem_cnt <= mem_cnt + 1;
      if (mem_cnt == LAT) begin
        mem_rdy     <= 1'b1;
        mem_rd_data <= line_for(bus.mm_addr_o);
        if (bus.mm_wr_o) begin
          mem_wa <= bus.mm_wr_addr_o;
          mem_wd <= bus.mm_wr_data_o;
        end
      end else begin
        mem_rdy <= 1'b0;
      end
    end else begin
      mem_cnt <= 0;
      mem_rdy <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (bus.mm_rd_o && bus.mm_wr_o) both_seen <= 1'b1;
  end

  assign bus.mm_data_rdy_i = mem_rdy | spur_rdy;
  assign bus.mm_rd_data_i  = mem_rd_data;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] ord [0:5];
  int         ic_n;
  int         dc_n;
  int         extra;
  int         gap;
  logic       found;
  logic [127:0] wb_line;

  initial begin
    bus.ic_req_i     = 1'b0;
    bus.ic_addr_i    = '0;
    bus.dc_rd_req_i  = 1'b0;
    bus.dc_rd_addr_i = '0;
    bus.dc_wb_req_i  = 1'b0;
    bus.dc_wb_addr_i = '0;
    bus.dc_wb_data_i = '0;
    wb_line = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    for (int k = 0; k < 6; k++) ord[k] = 2'b00;

    // Reset state
    repeat (2) step();
    check("rst_mm_rd",   128'(bus.mm_rd_o), 128'(0));
    check("rst_mm_wr",   128'(bus.mm_wr_o), 128'(0));
    check("rst_busy",    128'(busy_o), 128'(0));
    check("rst_owner",   128'(owner_o), 128'(0));
    check("rst_ic_rdy",  128'(bus.ic_rdy_o), 128'(0));
    check("rst_mm_addr", 128'(bus.mm_addr_o), 128'(0));
    check("rst_ic_data", bus.ic_data_o, 128'(0));
    rsn_i = 1'b1;
    step();

    // Single $I fill, latency 4
    $display("[TB] single IC fill");
    bus.ic_addr_i = 32'h0000_1040;
    bus.ic_req_i  = 1'b1;
    step();
    check("t1_mm_rd",   128'(bus.mm_rd_o), 128'(1));
    check("t1_mm_wr",   128'(bus.mm_wr_o), 128'(0));
    check("t1_mm_addr", 128'(bus.mm_addr_o), 128'(32'h1040));
    check("t1_owner",   128'(owner_o), 128'(2'b01));
    check("t1_busy",    128'(busy_o), 128'(1));
    for (int k = 2; k <= 5; k++) begin
      step();
      check("t1_rd_held", 128'(bus.mm_rd_o), 128'(1));
      check("t1_no_rdy",  128'(bus.ic_rdy_o), 128'(0));
    end
    step();
    check("t1_ic_rdy",  128'(bus.ic_rdy_o), 128'(1));
    check("t1_ic_data", bus.ic_data_o, line_for(32'h1040));
    check("t1_rd_low",  128'(bus.mm_rd_o), 128'(0));
    check("t1_idle",    128'(busy_o), 128'(0));
    check("t1_owner0",  128'(owner_o), 128'(0));
    bus.ic_req_i = 1'b0;
    step();
    check("t1_single_pulse", 128'(bus.ic_rdy_o), 128'(0));
    check("t1_no_regrant",   128'(bus.mm_rd_o), 128'(0));

    // Writeback and $D fill raised together: writeback goes first
    $display("[TB] writeback before dc fill");
    bus.dc_wb_addr_i = 32'h0000_2000;
    bus.dc_wb_data_i = wb_line;
    bus.dc_wb_req_i  = 1'b1;
    bus.dc_rd_addr_i = 32'h0000_3000;
    bus.dc_rd_req_i  = 1'b1;
    step();
    check("t2_mm_wr",      128'(bus.mm_wr_o), 128'(1));
    check("t2_mm_rd",      128'(bus.mm_rd_o), 128'(0));
    check("t2_wr_addr",    128'(bus.mm_wr_addr_o), 128'(32'h2000));
    check("t2_wr_data",    bus.mm_wr_data_o, wb_line);
    check("t2_owner",      128'(owner_o), 128'(2'b11));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.dc_wb_done_o) found = 1'b1;
    end
    check("t2_wb_done_seen", 128'(found), 128'(1));
    bus.dc_wb_req_i = 1'b0;
    check("t2_mem_wa",     128'(mem_wa), 128'(32'h2000));
    check("t2_mem_wd",     mem_wd, wb_line);
    check("t2_rd_not_yet", 128'(bus.mm_rd_o), 128'(0));
    check("t2_no_dc_rdy",  128'(bus.dc_rd_rdy_o), 128'(0));
    step();
    check("t2_dc_mm_rd",   128'(bus.mm_rd_o), 128'(1));
    check("t2_dc_mm_wr",   128'(bus.mm_wr_o), 128'(0));
    check("t2_dc_addr",    128'(bus.mm_addr_o), 128'(32'h3000));
    check("t2_dc_owner",   128'(owner_o), 128'(2'b10));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.dc_rd_rdy_o) found = 1'b1;
    end
    check("t2_dc_rdy_seen", 128'(found), 128'(1));
    check("t2_dc_data",     bus.dc_data_o, line_for(32'h3000));
    check("t2_wb_no_redo",  128'(bus.dc_wb_done_o), 128'(0));
    bus.dc_rd_req_i = 1'b0;
    check("t2_never_both",  128'(both_seen), 128'(0));
    step();

    // Both fill sources held: $D was served last, so grants run IC, DC, ...
    $display("[TB] round robin fills");
    bus.ic_addr_i    = 32'h0000_4000;
    bus.dc_rd_addr_i = 32'h0000_5000;
    bus.ic_req_i     = 1'b1;
    bus.dc_rd_req_i  = 1'b1;
    ic_n = 0;
    dc_n = 0;
    for (int i = 0; i < 150 && (ic_n + dc_n) < 6; i++) begin
      step();
      if (bus.ic_rdy_o) begin
        ord[ic_n + dc_n] = 2'b01;
        ic_n++;
        if (ic_n == 3) bus.ic_req_i = 1'b0;
      end
      if (bus.dc_rd_rdy_o && (ic_n + dc_n) < 6) begin
        ord[ic_n + dc_n] = 2'b10;
        dc_n++;
        if (dc_n == 3) bus.dc_rd_req_i = 1'b0;
      end
    end
    check("t3_order0", 128'(ord[0]), 128'(2'b01));
    check("t3_order1", 128'(ord[1]), 128'(2'b10));
    check("t3_order2", 128'(ord[2]), 128'(2'b01));
    check("t3_order3", 128'(ord[3]), 128'(2'b10));
    check("t3_order4", 128'(ord[4]), 128'(2'b01));
    check("t3_order5", 128'(ord[5]), 128'(2'b10));
    bus.ic_req_i    = 1'b0;
    bus.dc_rd_req_i = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.ic_rdy_o) ic_n++;
      if (bus.dc_rd_rdy_o) dc_n++;
      if (bus.mm_rd_o || bus.mm_wr_o) extra++;
    end
    check("t3_ic_pulses", 128'(ic_n), 128'(3));
    check("t3_dc_pulses", 128'(dc_n), 128'(3));
    check("t3_quiet",     128'(extra), 128'(0));
    check("t3_ic_data",   bus.ic_data_o, line_for(32'h4000));
    check("t3_dc_data",   bus.dc_data_o, line_for(32'h5000));

    // Spurious memory completion while IDLE
    $display("[TB] spurious completion");
    spur_rdy = 1'b1;
    step();
    spur_rdy = 1'b0;
    check("t4_busy",    128'(busy_o), 128'(0));
    check("t4_ic_rdy",  128'(bus.ic_rdy_o), 128'(0));
    check("t4_dc_rdy",  128'(bus.dc_rd_rdy_o), 128'(0));
    check("t4_wb_done", 128'(bus.dc_wb_done_o), 128'(0));
    check("t4_mm_req",  128'({bus.mm_rd_o, bus.mm_wr_o}), 128'(0));
    check("t4_owner",   128'(owner_o), 128'(0));
    check("t4_ic_hold", bus.ic_data_o, line_for(32'h4000));
    step();
    check("t4_busy_after", 128'(busy_o), 128'(0));

    // Single requester back-to-back: one fill every LAT+3 cycles
    $display("[TB] back-to-back throughput");
    bus.ic_addr_i = 32'h0000_8000;
    bus.ic_req_i  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.ic_rdy_o) found = 1'b1;
    end
    check("t5_first_rdy", 128'(found), 128'(1));
    found = 1'b0;
    gap = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      gap++;
      if (bus.ic_rdy_o) found = 1'b1;
    end
    bus.ic_req_i = 1'b0;
    check("t5_period",  128'(gap), 128'(LAT + 3));
    check("t5_ic_data", bus.ic_data_o, line_for(32'h8000));
    step();

    // Asynchronous reset in the second cycle of RD_WAIT
    $display("[TB] reset mid transaction");
    bus.ic_addr_i = 32'h0000_6000;
    bus.ic_req_i  = 1'b1;
    step();
    step();
    check("t6_in_rd", 128'(bus.mm_rd_o), 128'(1));
    #2;
    rsn_i = 1'b0;
    #1;
    check("t6_mm_rd",      128'(bus.mm_rd_o), 128'(0));
    check("t6_busy",       128'(busy_o), 128'(0));
    check("t6_owner",      128'(owner_o), 128'(0));
    check("t6_mm_addr",    128'(bus.mm_addr_o), 128'(0));
    check("t6_wr_addr",    128'(bus.mm_wr_addr_o), 128'(0));
    check("t6_wr_data",    bus.mm_wr_data_o, 128'(0));
    check("t6_ic_data",    bus.ic_data_o, 128'(0));
    check("t6_dc_data",    bus.dc_data_o, 128'(0));
    bus.ic_req_i = 1'b0;
    step();
    step();
    rsn_i = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.ic_rdy_o || bus.mm_rd_o) extra++;
    end
    check("t6_no_late_rdy", 128'(extra), 128'(0));
    bus.ic_addr_i = 32'h0000_7000;
    bus.ic_req_i  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      step();
      if (bus.mm_rd_o) found = 1'b1;
    end
    check("t6_fresh_rd",   128'(found), 128'(1));
    check("t6_fresh_addr", 128'(bus.mm_addr_o), 128'(32'h7000));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.ic_rdy_o) found = 1'b1;
    end
    bus.ic_req_i = 1'b0;
    check("t6_fresh_rdy",  128'(found), 128'(1));
    check("t6_fresh_data", bus.ic_data_o, line_for(32'h7000));
    step();
    check("t_end_never_both", 128'(both_seen), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
